// File: rtl/cla_seq_ctrl_if.sv
// Operand request / result handshake bundle between a source and the CLA sequencer.
// The source holds the master modport and the sequencer holds the slave modport.
interface cla_seq_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_cout
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_cout
  );
endinterface

// File: rtl/cla_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder sequencer.
// It drives one external 4-bit CLA slice, one nibble per cycle, LSB first.
module cla_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  cla_seq_ctrl_if.slave        bus,
  output logic                 busy,
  output logic [3:0]           slc_a,
  output logic [3:0]           slc_b,
  output logic                 slc_cin,
  input  logic [3:0]           slc_sum,
  input  logic                 slc_cout
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
    $error("cla_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  logic [1:0]       state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             carry_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;

  logic [WIDTH-1:0] result_d;
  logic             accept;

  // Current result with the active nibble replaced by the slice output.
  always_comb begin
    result_d = result_q;
    result_d[{idx_q, 2'b00} +: 4] = slc_sum;
  end

  always_comb begin
    slc_a   = 4'h0;
    slc_b   = 4'h0;
    slc_cin = 1'b0;
    if (state_q == StRun) begin
      slc_a   = opa_q[{idx_q, 2'b00} +: 4];
      slc_b   = opb_q[{idx_q, 2'b00} +: 4];
      slc_cin = carry_q;
    end
  end

  always_comb begin
    bus.in_ready = ena && (state_q == StIdle);
    accept       = bus.in_ready && bus.in_valid;
    busy         = (state_q == StRun) || (state_q == StDone);
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      opa_q       <= '0;
      opb_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
    end else if (ena) begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            opa_q    <= bus.in_a;
            opb_q    <= bus.in_b;
            carry_q  <= bus.in_cin;
            idx_q    <= '0;
            result_q <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          result_q <= result_d;
          carry_q  <= slc_cout;
          if (idx_q == LastIdx) begin
            // idx stays put on the last nibble so it never leaves 0..NIBBLES-1.
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            out_sum_q   <= result_d;
            out_cout_q  <= slc_cout;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
